// File: rtl/xor_sf.sv
// xor_sf: free-running Fibonacci LFSR pattern source.
// Shifts left each clock; XOR of tapped bits enters the LSB.
module xor_sf #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
    parameter logic [WIDTH-1:0] SEED  = 4'b0001
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] out
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("xor_sf: WIDTH %0d outside 2..32", WIDTH);
    end

    // An all-zero seed would park the register in the lock-up state.
    if (SEED == '0) begin : g_bad_seed
        $error("xor_sf: SEED must be non-zero");
    end

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             fb;

    always_comb begin
        fb      = ^(state_q & TAPS);
        state_d = {state_q[WIDTH-2:0], fb};
        // Zero never feeds itself out; reload the seed instead.
        if (state_q == '0) begin
            state_d = SEED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign out = state_q;

endmodule

// File: tb/tb_xor_sf.sv
// tb_xor_sf: directed-vector scoreboard bench for xor_sf.
// Stimulus queues expected values; a monitor pops after each edge.
module tb_xor_sf;

    logic       clk = 1'b0;
    logic       reset4 = 1'b1;
    logic       reset3 = 1'b1;
    logic [3:0] out4;
    logic [2:0] out3;

    always #5 clk = ~clk;

    xor_sf dut4 (
        .clk   (clk),
        .reset (reset4),
        .out   (out4)
    );

    xor_sf #(
        .WIDTH (3),
        .TAPS  (3'b110),
        .SEED  (3'b001)
    ) dut3 (
        .clk   (clk),
        .reset (reset3),
        .out   (out3)
    );

    typedef struct {
        logic [3:0] exp;
        bit         w3;
        bit         cov;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [15:0] seen = '0;

    logic [3:0] seq4 [15] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
        4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
        4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000
    };
    logic [2:0] seq3 [7] = '{
        3'b001, 3'b010, 3'b101, 3'b011,
        3'b111, 3'b110, 3'b100
    };

    // Monitor: output is valid every cycle, sample just after the edge.
    always @(posedge clk) begin
        exp_t       e;
        logic [3:0] act;
        #1;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            act = e.w3 ? {1'b0, out3} : out4;
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %b expected %b",
                         e.name, act, e.exp);
            end
            if (e.cov && !$isunknown(act)) begin
                seen[act] = 1'b1;
            end
        end
    end

    task automatic push(input logic [3:0] exp, input bit w3,
                        input bit cov, input string name);
        exp_t e;
        e.exp  = exp;
        e.w3   = w3;
        e.cov  = cov;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(input logic r4, input logic r3,
                        input logic [3:0] exp, input bit w3,
                        input bit cov, input string name);
        @(negedge clk);
        reset4 = r4;
        reset3 = r3;
        push(exp, w3, cov, name);
    endtask

    initial begin
        step(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, "reset_edge");
        step(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, "reset_hold");

        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, seq4[(i + 1) % 15], 1'b0,
                 (i < 15), "seq");
        end

        step(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, "mid_pre");
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, seq4[i + 1], 1'b0, 1'b0, "mid_run");
        end
        step(1'b1, 1'b1, 4'b0001, 1'b0, 1'b0, "mid_reset");
        step(1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, "mid_next");

        @(negedge clk);
        dut4.state_q = 4'b0000;
        reset4 = 1'b0;
        push(4'b0001, 1'b0, 1'b0, "lockup");
        step(1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, "lockup_next");

        step(1'b0, 1'b1, 4'b0001, 1'b1, 1'b0, "w3_reset");
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b0, {1'b0, seq3[(i + 1) % 7]},
                 1'b1, 1'b0, "w3_seq");
        end

        for (int i = 0; i < 10; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0",
                     sb.size());
        end

        n_cmp++;
        if (seen !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL coverage: got %h expected fffe", seen);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
